spi_xfer_arbiter: RTL and testbench

Transaction controller that shares one SPI master link between two requesters, e.g. CPU load/store port and a DMA/boot loader. It arbitrates round-robin, drives chip-select, generates a divided SPI clock, and runs one full-duplex W_DATA-bit mode-0 transfer per grant, MSB first. It returns the received word with a one-cycle done pulse. It replaces free-running serializers driven directly by the CPU clock with a sequenced, framed transaction.

---
 rtl/spi_xfer_arbiter.sv | 160 ++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one SPI master link between two requesters.
// Round-robin arbitration in IDLE, then one framed mode-0, MSB-first,
// full-duplex transfer per grant, with a one-cycle done pulse to the owner.
module spi_xfer_arbiter #(
   parameter int W_DATA  = 32,
   parameter int CLK_DIV = 2,
   parameter int N_CS    = 2,
   parameter int W_SEL   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [W_DATA-1:0] tx_data_0,
   input  logic [W_DATA-1:0] tx_data_1,
   input  logic [W_SEL-1:0]  slave_0,
   input  logic [W_SEL-1:0]  slave_1,
   output logic [1:0]        grant,
   output logic [1:0]        done,
   output logic [W_DATA-1:0] rx_data,
   output logic              busy,
   output logic              spi_sclk,
   output logic              spi_mosi,
   output logic [N_CS-1:0]   spi_cs_n,
   input  logic              spi_miso
);

   localparam int W_DIV = $clog2(CLK_DIV) + 1;
   localparam int W_BIT = (W_DATA > 1) ? $clog2(W_DATA) : 1;
   localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(CLK_DIV - 1);
   localparam logic [W_BIT-1:0] BIT_TOP  = W_BIT'(W_DATA - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            state;
   logic [W_DIV-1:0]  div;
   logic [W_BIT-1:0]  bit_cnt;
   logic [W_DATA-1:0] tx_sh;
   logic [W_DATA-1:0] rx_sh;
   logic              owner;
   logic              last;

   logic              pick;
   logic [W_DATA-1:0] pick_tx;
   logic [W_SEL-1:0]  pick_sel;
   logic              div_last;

   // Active-low one-hot chip-select; indices >= N_CS select nothing.
   function automatic logic [N_CS-1:0] cs_decode(input logic [W_SEL-1:0] s);
      logic [N_CS-1:0] m;
      m = '1;
      for (int unsigned i = 0; i < N_CS; i++) begin
         if (s == W_SEL'(i)) m[i] = 1'b0;
      end
      return m;
   endfunction

   // Round-robin choice: on a tie the requester that did not go last wins.
   always_comb begin
      pick = 1'b0;
      if (req == 2'b11) pick = ~last;
      else if (req[1])  pick = 1'b1;
      pick_tx  = pick ? tx_data_1 : tx_data_0;
      pick_sel = pick ? slave_1   : slave_0;
      div_last = (div == DIV_LAST);
   end

   // Transaction sequencer: arbitration, framing, SCLK division and shifting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         div      <= '0;
         bit_cnt  <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         owner    <= 1'b0;
         last     <= 1'b1;
         grant    <= '0;
         done     <= '0;
         rx_data  <= '0;
         busy     <= 1'b0;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         spi_cs_n <= '1;
      end else begin
         grant <= '0;
         done  <= '0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  owner       <= pick;
                  last        <= pick;
                  grant[pick] <= 1'b1;
                  busy        <= 1'b1;
                  tx_sh       <= pick_tx;
                  rx_sh       <= '0;
                  spi_cs_n    <= cs_decode(pick_sel);
                  spi_mosi    <= pick_tx[W_DATA-1];
                  spi_sclk    <= 1'b0;
                  div         <= '0;
                  state       <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (div_last) begin
                  div     <= '0;
                  bit_cnt <= BIT_TOP;
                  state   <= S_SHIFT;
               end else begin
                  div <= div + 1'b1;
               end
            end
            S_SHIFT: begin
               if (div_last) begin
                  div <= '0;
                  if (!spi_sclk) begin
                     spi_sclk <= 1'b1;
                     rx_sh    <= {rx_sh[W_DATA-2:0], spi_miso};
                  end else begin
                     spi_sclk <= 1'b0;
                     if (bit_cnt == '0) begin
                        state <= S_HOLD;
                     end else begin
                        bit_cnt  <= bit_cnt - 1'b1;
                        tx_sh    <= {tx_sh[W_DATA-2:0], 1'b0};
                        spi_mosi <= tx_sh[W_DATA-2];
                     end
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            S_HOLD: begin
               if (div_last) begin
                  div      <= '0;
                  spi_cs_n <= '1;
                  spi_mosi <= 1'b0;
                  state    <= S_DONE;
               end else begin
                  div <= div + 1'b1;
               end
            end
            S_DONE: begin
               rx_data     <= rx_sh;
               done[owner] <= 1'b1;
               busy        <= 1'b0;
               div         <= '0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Testbench for spi_xfer_arbiter: a behavioural mode-0 slave drives miso
// from a chosen word and captures mosi; expected results come from the
// transaction-level rules (latency, framing, round-robin order).
module tb_spi_xfer_arbiter;

   localparam int W = 32;
   localparam int LAT2 = (2 * W + 2) * 2 + 1;   // CLK_DIV = 2
   localparam int LAT1 = (2 * W + 2) * 1 + 1;   // CLK_DIV = 1
   localparam int CSLOW2 = (2 * W + 2) * 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;

   // DUT A (CLK_DIV = 2)
   logic [1:0]    req = '0;
   logic [W-1:0]  tx0 = '0, tx1 = '0;
   logic [0:0]    sl0 = '0, sl1 = '0;
   logic [1:0]    grant, done;
   logic [W-1:0]  rx_data;
   logic          busy, sclk, mosi, miso;
   logic [1:0]    cs_n;

   // DUT B (CLK_DIV = 1), loopback
   logic [1:0]    req_b = '0;
   logic [W-1:0]  tx0_b = '0, tx1_b = '0;
   logic [0:0]    sl0_b = '0, sl1_b = '0;
   logic [1:0]    grant_b, done_b;
   logic [W-1:0]  rx_b;
   logic          busy_b, sclk_b, mosi_b;
   logic [1:0]    cs_n_b;

   int total = 0;
   int bad = 0;

   // behavioural slave for DUT A
   logic [W-1:0]  slv_word = '0;
   logic          loop_en = 1'b0;
   int            rise_total = 0;
   int            fall_total = 0;
   int            fall_base = 0;
   logic [W-1:0]  mosi_cap = '0;
   int            k_bit;

   always #5 clk = ~clk;

   spi_xfer_arbiter #(.W_DATA(W), .CLK_DIV(2), .N_CS(2), .W_SEL(1)) u_dut (
      .clk(clk), .rst(rst), .req(req), .tx_data_0(tx0), .tx_data_1(tx1),
      .slave_0(sl0), .slave_1(sl1), .grant(grant), .done(done),
      .rx_data(rx_data), .busy(busy), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_cs_n(cs_n), .spi_miso(miso)
   );

   spi_xfer_arbiter #(.W_DATA(W), .CLK_DIV(1), .N_CS(2), .W_SEL(1)) u_dut_b (
      .clk(clk), .rst(rst), .req(req_b), .tx_data_0(tx0_b), .tx_data_1(tx1_b),
      .slave_0(sl0_b), .slave_1(sl1_b), .grant(grant_b), .done(done_b),
      .rx_data(rx_b), .busy(busy_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b),
      .spi_cs_n(cs_n_b), .spi_miso(mosi_b)
   );

   always @(posedge sclk) begin
      rise_total = rise_total + 1;
      mosi_cap = {mosi_cap[W-2:0], mosi};
   end

   always @(negedge sclk) fall_total = fall_total + 1;

   always_comb begin
      k_bit = fall_total - fall_base;
      if (loop_en)                 miso = mosi;
      else if (k_bit >= 0 && k_bit < W) miso = slv_word[W-1-k_bit];
      else                         miso = 1'b0;
   end

   // one complete single-requester transaction on DUT A with full checking
   task automatic do_xfer(input int r, input logic [W-1:0] tx, input logic [0:0] sel,
                          input logic [W-1:0] slv, input logic lb, input string nm);
      int n, rise0, cslow;
      logic [1:0] expg, seen;
      logic mhi;
      logic [W-1:0] exp_rx;
      expg = 2'b01 << r;
      exp_rx = lb ? tx : slv;
      slv_word = slv;
      loop_en = lb;
      fall_base = fall_total;
      rise0 = rise_total;
      if (r == 0) begin tx0 = tx; sl0 = sel; end
      else begin tx1 = tx; sl1 = sel; end
      req[r] = 1'b1;
      n = 0;
      @(negedge clk);
      while (grant == 2'b00 && n < 300) begin @(negedge clk); n++; end
      total++;
      if (grant !== expg) begin
         bad++; $display("FAIL %s grant: got %b want %b", nm, grant, expg);
      end
      req[r] = 1'b0;
      n = 0; cslow = 0; seen = '0; mhi = 1'b0;
      while (done == 2'b00 && n < 400) begin
         if (cs_n != 2'b11) cslow++;
         seen = seen | ~cs_n;
         mhi = mhi | mosi;
         @(negedge clk);
         n++;
      end
      total++;
      if (n != LAT2) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, n, LAT2); end
      total++;
      if (done !== expg) begin bad++; $display("FAIL %s done: got %b want %b", nm, done, expg); end
      total++;
      if (rx_data !== exp_rx) begin bad++; $display("FAIL %s rx_data: got %h want %h", nm, rx_data, exp_rx); end
      total++;
      if (busy !== 1'b0 || cs_n !== 2'b11) begin
         bad++; $display("FAIL %s done_cycle: busy=%b cs_n=%b want 0/11", nm, busy, cs_n);
      end
      total++;
      if (rise_total - rise0 != W) begin
         bad++; $display("FAIL %s sclk_rises: got %0d want %0d", nm, rise_total - rise0, W);
      end
      total++;
      if (mosi_cap !== tx) begin bad++; $display("FAIL %s mosi_word: got %h want %h", nm, mosi_cap, tx); end
      total++;
      if (cslow != CSLOW2) begin bad++; $display("FAIL %s cs_low_cycles: got %0d want %0d", nm, cslow, CSLOW2); end
      total++;
      if (seen !== (2'b01 << sel)) begin bad++; $display("FAIL %s cs_select: got %b want %b", nm, seen, 2'b01 << sel); end
      total++;
      if (mhi !== (tx != '0)) begin bad++; $display("FAIL %s mosi_activity: got %b want %b", nm, mhi, tx != '0); end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_ctl: grant=%b done=%b busy=%b want 00/00/0", grant, done, busy);
      end
      total++;
      if (rx_data !== '0) begin bad++; $display("FAIL reset_rx: got %h want 0", rx_data); end
      total++;
      if (sclk !== 1'b0 || mosi !== 1'b0 || cs_n !== 2'b11) begin
         bad++; $display("FAIL reset_spi: sclk=%b mosi=%b cs_n=%b want 0/0/11", sclk, mosi, cs_n);
      end
      total++;
      if (cs_n_b !== 2'b11 || busy_b !== 1'b0) begin
         bad++; $display("FAIL reset_b: cs_n=%b busy=%b want 11/0", cs_n_b, busy_b);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_loopback;
      do_xfer(0, 32'hA5A5_0F0F, 1'b1, '0, 1'b1, "loopback");
      @(negedge clk);
   endtask

   task automatic test_miso_ones;
      do_xfer(0, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, "miso_ones");
      @(negedge clk);
   endtask

   task automatic test_random;
      for (int i = 0; i < 6; i++) begin
         do_xfer(int'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom, 1'b0, "random");
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   // both requests held from reset: model pointer starts at 1, tie goes to ~last
   task automatic test_fairness;
      logic mlast;
      int exp_o, cyc, gcyc, prev_g, n;
      mlast = 1'b1;
      rst = 1'b0;
      tx0 = $urandom; tx1 = $urandom; sl0 = 1'b0; sl1 = 1'b1;
      loop_en = 1'b1;
      req = 2'b11;
      @(negedge clk);
      rst = 1'b1;
      cyc = 0; prev_g = 0;
      for (int k = 0; k < 4; k++) begin
         exp_o = mlast ? 0 : 1;
         mlast = 1'(exp_o);
         n = 0;
         while (grant == 2'b00 && n < 300) begin @(negedge clk); cyc++; n++; end
         gcyc = cyc;
         total++;
         if (grant !== (2'b01 << exp_o)) begin
            bad++; $display("FAIL fair_grant%0d: got %b want %b", k, grant, 2'b01 << exp_o);
         end
         if (k > 0) begin
            total++;
            if (gcyc - prev_g != LAT2 + 1) begin
               bad++; $display("FAIL fair_spacing%0d: got %0d want %0d", k, gcyc - prev_g, LAT2 + 1);
            end
         end
         prev_g = gcyc;
         n = 0;
         while (done == 2'b00 && n < 400) begin @(negedge clk); cyc++; n++; end
         total++;
         if (done !== (2'b01 << exp_o)) begin
            bad++; $display("FAIL fair_done%0d: got %b want %b", k, done, 2'b01 << exp_o);
         end
         total++;
         if (rx_data !== (exp_o == 0 ? tx0 : tx1)) begin
            bad++; $display("FAIL fair_rx%0d: got %h want %h", k, rx_data, exp_o == 0 ? tx0 : tx1);
         end
         total++;
         if (cs_n !== 2'b11 || busy !== 1'b0) begin
            bad++; $display("FAIL fair_idle%0d: cs_n=%b busy=%b want 11/0", k, cs_n, busy);
         end
         if (k == 3) req = 2'b00;
         @(negedge clk); cyc++;
      end
      @(negedge clk);
   endtask

   // req[1] arrives mid-shift of requester 0: must wait for done[0]
   task automatic test_late_req;
      int n, early;
      tx0 = $urandom; tx1 = $urandom; sl0 = 1'b1; sl1 = 1'b0;
      loop_en = 1'b1;
      req[0] = 1'b1;
      n = 0;
      @(negedge clk);
      while (grant == 2'b00 && n < 300) begin @(negedge clk); n++; end
      req[0] = 1'b0;
      repeat (40) @(negedge clk);
      req[1] = 1'b1;
      n = 0; early = 0;
      while (done == 2'b00 && n < 400) begin
         if (grant != 2'b00) early++;
         @(negedge clk); n++;
      end
      total++;
      if (early != 0 || grant !== 2'b00) begin
         bad++; $display("FAIL late_no_early_grant: early=%0d grant=%b want 0/00", early, grant);
      end
      total++;
      if (done !== 2'b01) begin bad++; $display("FAIL late_done0: got %b want 01", done); end
      @(negedge clk);
      total++;
      if (grant !== 2'b10) begin bad++; $display("FAIL late_grant1: got %b want 10", grant); end
      req[1] = 1'b0;
      n = 0;
      while (done == 2'b00 && n < 400) begin @(negedge clk); n++; end
      total++;
      if (done !== 2'b10 || rx_data !== tx1) begin
         bad++; $display("FAIL late_done1: done=%b rx=%h want 10/%h", done, rx_data, tx1);
      end
      @(negedge clk);
   endtask

   // asynchronous reset mid-shift, then pointer must be back at last=1
   task automatic test_mid_reset;
      int n, rise0, dcount;
      tx0 = $urandom; sl0 = 1'b0;
      loop_en = 1'b1;
      rise0 = rise_total;
      req[0] = 1'b1;
      n = 0;
      @(negedge clk);
      while (grant == 2'b00 && n < 300) begin @(negedge clk); n++; end
      req[0] = 1'b0;
      n = 0;
      while (rise_total - rise0 < 17 && n < 400) begin @(negedge clk); n++; end
      total++;
      if (rise_total - rise0 < 17) begin bad++; $display("FAIL mid_reset_reach: rises=%0d want 17", rise_total - rise0); end
      rst = 1'b0;
      #1;
      total++;
      if (cs_n !== 2'b11 || sclk !== 1'b0 || busy !== 1'b0 || rx_data !== '0) begin
         bad++; $display("FAIL mid_reset_now: cs_n=%b sclk=%b busy=%b rx=%h want 11/0/0/0",
                         cs_n, sclk, busy, rx_data);
      end
      @(negedge clk);
      rst = 1'b1;
      dcount = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done != 2'b00) dcount++;
      end
      total++;
      if (dcount != 0) begin bad++; $display("FAIL mid_reset_no_done: got %0d want 0", dcount); end
      // with both pending, a reset pointer gives requester 0 the tie
      tx1 = $urandom; sl1 = 1'b1;
      req[1] = 1'b1;
      do_xfer(0, $urandom, 1'b0, '0, 1'b1, "post_reset0");
      do_xfer(1, tx1, 1'b1, '0, 1'b1, "post_reset1");
      @(negedge clk);
   endtask

   task automatic test_clkdiv1;
      logic [W-1:0] v;
      int n;
      for (int i = 0; i < 3; i++) begin
         v = (i == 0) ? 32'h8000_0001 : $urandom;
         tx0_b = v; sl0_b = 1'b0;
         req_b[0] = 1'b1;
         n = 0;
         @(negedge clk);
         while (grant_b == 2'b00 && n < 300) begin @(negedge clk); n++; end
         req_b[0] = 1'b0;
         n = 0;
         while (done_b == 2'b00 && n < 400) begin @(negedge clk); n++; end
         total++;
         if (n != LAT1) begin bad++; $display("FAIL div1_latency: got %0d want %0d", n, LAT1); end
         total++;
         if (done_b !== 2'b01 || rx_b !== v) begin
            bad++; $display("FAIL div1_rx: done=%b rx=%h want 01/%h", done_b, rx_b, v);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_miso_ones();
      test_random();
      test_fairness();
      test_late_req();
      test_mid_reset();
      test_clkdiv1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
